// File: rtl/ex_ctrl_seq.sv
// rtl/ex_ctrl_seq.sv - RV32 EX-stage control sequencer; M-extension sequencer enabled by EX_CTRL_RV32M_EN
module ex_ctrl_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_stall,
    input  logic       i_flush,
    output logic       o_out_valid,
    output logic       o_a_sel,
    output logic       o_b_sel,
    output logic [2:0] o_branch_alu_op,
    output logic [3:0] o_alu_op,
    output logic [2:0] o_md_op,
    output logic       o_md_start,
    output logic       o_md_busy,
    output logic       o_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
        $error("ex_ctrl_seq: MUL_CYCLES and DIV_CYCLES must be >= 1");
    end

    logic       w_legal;
    logic       w_a_sel;
    logic       w_b_sel;
    logic [2:0] w_br_op;
    logic [3:0] w_alu_op;
    logic       w_is_mext;
    logic       w_md_busy;
    logic       w_accept;
    logic       w_retire;

    logic       r_out_valid;
    logic       r_a_sel;
    logic       r_b_sel;
    logic [2:0] r_br_op;
    logic [3:0] r_alu_op;
    logic       r_illegal;

`ifdef EX_CTRL_RV32M_EN
    typedef enum logic {IDLE, MD_BUSY} state_t;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_md_start;
    logic          w_md_start_nxt;
    logic [2:0]    r_md_op;
    logic [2:0]    w_md_op_nxt;
`endif

    assign w_is_mext = (i_opcode == OPC_OP) && (i_funct7 == 7'b0000001);

    // Fields left at defaults by any path that clears w_legal
    always_comb begin
        w_legal  = 1'b1;
        w_a_sel  = 1'b0;
        w_b_sel  = 1'b1;
        w_br_op  = 3'b011;
        w_alu_op = 4'b0000;
        case (i_opcode)
            OPC_LUI:    w_alu_op = 4'b1001;
            OPC_AUIPC:  w_a_sel  = 1'b1;
            OPC_JAL: begin
                w_a_sel = 1'b1;
                w_br_op = 3'b010;
            end
            OPC_JALR: begin
                w_br_op  = 3'b010;
                w_alu_op = 4'b1010;
            end
            OPC_BRANCH: begin
                w_a_sel = 1'b1;
                w_br_op = i_funct3;
            end
            OPC_LOAD, OPC_STORE: ;
            OPC_OPIMM:
                w_alu_op = (i_funct3 == 3'b101) ? {i_funct7[5], i_funct3} : {1'b0, i_funct3};
            OPC_OP: begin
                if (w_is_mext) begin
`ifdef EX_CTRL_RV32M_EN
                    w_b_sel = 1'b0;
`else
                    w_legal = 1'b0;
`endif
                end else begin
                    w_b_sel  = 1'b0;
                    w_alu_op = (i_funct3 == 3'b000 || i_funct3 == 3'b101) ?
                               {i_funct7[5], i_funct3} : {1'b0, i_funct3};
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign o_in_ready = !i_flush && !w_md_busy && (!r_out_valid || !i_stall);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_retire   = r_out_valid && !i_stall && !w_md_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_a_sel     <= 1'b0;
            r_b_sel     <= 1'b0;
            r_br_op     <= 3'b011;
            r_alu_op    <= 4'b0000;
            r_illegal   <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_a_sel     <= w_a_sel;
            r_b_sel     <= w_b_sel;
            r_br_op     <= w_br_op;
            r_alu_op    <= w_alu_op;
            r_illegal   <= !w_legal;
        end else if (w_retire) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef EX_CTRL_RV32M_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_md_start <= 1'b0;
            r_md_op    <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_md_start <= w_md_start_nxt;
            r_md_op    <= w_md_op_nxt;
        end
    end

    // Counter runs regardless of stall; only flush or reset cut an op short
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_md_start_nxt = 1'b0;
        w_md_op_nxt    = r_md_op;
        if (i_flush) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_md_op_nxt = (w_is_mext) ? i_funct3 : 3'b000;
                        if (w_is_mext) begin
                            w_state_nxt    = MD_BUSY;
                            w_count_nxt    = i_funct3[2] ? DIV_LOAD : MUL_LOAD;
                            w_md_start_nxt = 1'b1;
                        end
                    end
                end
                MD_BUSY: begin
                    if (r_count == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_count_nxt = r_count - 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_md_busy  = (r_state == MD_BUSY);
    assign o_md_start = r_md_start;
    assign o_md_op    = r_md_op;
`else
    assign w_md_busy  = 1'b0;
    assign o_md_start = 1'b0;
    assign o_md_op    = 3'b000;
`endif

    assign o_md_busy       = w_md_busy;
    assign o_out_valid     = r_out_valid;
    assign o_a_sel         = r_a_sel;
    assign o_b_sel         = r_b_sel;
    assign o_branch_alu_op = r_br_op;
    assign o_alu_op        = r_alu_op;
    assign o_illegal       = r_illegal;

endmodule

// File: doc/ex_ctrl_seq.md
# ex_ctrl_seq

Registered, stall/flush-aware execute-stage control sequencer for the RV32 core. Decodes `opcode`/`funct3`/`funct7` into EX control fields, holds them in a one-entry pipeline register with a valid/ready handshake, and flags illegal opcodes. With the M extension compiled in, it also runs a counter-based multi-cycle sequencer that holds the stage busy for parametrised MUL/DIV latencies.

## Interface

- `MUL_CYCLES`, default 4: EX busy cycles for MUL/MULH/MULHSU/MULHU; legal range ≥ 1.
- `DIV_CYCLES`, default 32: EX busy cycles for DIV/DIVU/REM/REMU; legal range ≥ 1.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  ID presents an instruction
- `in_ready`  out  1  EX accepts this cycle (combinational)
- `opcode`  in  7  instruction[6:0]
- `funct3`  in  3  instruction[14:12]
- `funct7`  in  7  instruction[31:25]
- `stall`  in  1  downstream cannot take EX result; hold the register
- `flush`  in  1  squash the held instruction (branch redirect)
- `out_valid`  out  1  register holds a live instruction
- `a_sel`  out  1  0 selects data1, 1 selects pc
- `b_sel`  out  1  0 selects data2, 1 selects imm
- `branch_alu_op`  out  3  branch comparator op
- `alu_op`  out  4  ALU op
- `md_op`  out  3  M-extension op (funct3)
- `md_start`  out  1  one-cycle pulse that launches the MUL/DIV unit
- `md_busy`  out  1  multi-cycle op in progress
- `illegal`  out  1  held instruction is illegal

## Operation

- Legal opcodes:
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH
  - 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP
  - Every other opcode is illegal.
- `a_sel` = 1 for AUIPC, JAL and BRANCH; otherwise 0.
- `b_sel` = 0 for OP; otherwise 1.
- `branch_alu_op`:
  - 010 for JAL/JALR
  - `funct3` for BRANCH
  - 011 otherwise
- `alu_op`:
  - 1001 for LUI; 1010 for JALR.
  - OP/OP-IMM: {0,`funct3`}, except funct3=000 on OP and funct3=101 on OP/OP-IMM, which use {`funct7[5]`,`funct3`}.
  - 0000 for all other instructions.
- M op: OP with `funct7`=0000001.
  - Outputs: `md_op`=`funct3`, `alu_op`=0000, `a_sel`=0, `b_sel`=0, `branch_alu_op`=011.
  - `funct3[2]`=0 selects MUL latency; `funct3[2]`=1 selects DIV latency.
- Illegal instruction: `illegal`=1, `out_valid`=1, all other control fields take their default values (0/1/011/0000, `md_op`=000).
- Accept condition: `in_valid && in_ready`.
  - `in_ready` = `!flush && !md_busy && (!out_valid || !stall)`.
- Retire condition: `out_valid && !stall && !md_busy`. A retire with no accept clears `out_valid`.
- FSM states:
  - IDLE → MD_BUSY on accepting an M op: counter loaded with latency−1, `md_busy` set.
  - MD_BUSY: counter decrements each cycle; the state leaves for IDLE at the edge where the counter equals 0.
  - `stall` does not pause the counter.
- Counter width: `$clog2(max(MUL_CYCLES,DIV_CYCLES)+1)`.
- Priority, highest first:
  1. `rst`
  2. `flush`: clears `out_valid`, `md_busy`, counter and `illegal`, returns to IDLE, and blocks any accept that cycle.
  3. accept/retire

## Timing

- Reset values: all outputs 0 except `branch_alu_op`=011. State is IDLE; counter is 0.
- Decode latency is 1 cycle: fields appear the cycle after accept and hold stable while `out_valid && (stall || md_busy)`.
- Back-to-back accepts sustain 1 instruction/cycle when `stall`=0.
- M op accepted at edge T:
  - `md_start` is high during cycle T+1 only.
  - `md_busy` is high for exactly N cycles (N = `MUL_CYCLES` or `DIV_CYCLES`).
  - Earliest retire is cycle T+N+1.
- Flush mid-operation aborts the op: `md_busy` is low the next cycle and no further `md_start` is issued.
- `rst` asserted mid-operation: same effect as flush, plus all fields return to their reset values.

## Configuration

- `EX_CTRL_RV32M_EN`
  - Defined: M decode, the MD_BUSY state and counter, `md_start`/`md_busy` generation.
  - Undefined: OP with `funct7`=0000001 is illegal; `md_busy`, `md_start` and `md_op` are tied to 0; no counter logic is synthesised.

## Test plan

- Reset, then accept ADD (0110011/000/0000000) followed by SUB (funct7=0100000). Required: `alu_op`=0000 then 1000, `b_sel`=0, `in_ready`=1 throughout.
- JALR then BEQ (1100011/000). Required: `alu_op`=1010, `branch_alu_op`=010; then `a_sel`=1, `branch_alu_op`=000, `alu_op`=0000.
- MUL with `MUL_CYCLES`=4. Required: `md_start` pulses once, `md_busy` high exactly 4 cycles, `in_ready`=0 while busy; DIVU with `DIV_CYCLES`=32 gives 32 busy cycles.
- `stall` held 3 cycles on a held SLLI. Required: fields and `out_valid` stable, `in_ready`=0, no instruction lost or duplicated.
- `flush` in the 2nd busy cycle of DIV. Required: next cycle `out_valid`=0, `md_busy`=0, and an instruction presented during the flush cycle is not accepted.
- Opcode 1111111, and MUL with the macro undefined. Required: `illegal`=1, `alu_op`=0000, `md_busy` stays 0.
